md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the 5-stage pipeline.
- Accepts mult/div/mthi/mtlo ops issued from the E stage and owns the HI/LO registers.
- Sequences the fixed-latency operation with a busy counter.
- Raises a D-stage stall whenever an HI/LO-dependent instruction would observe a busy unit or a same-cycle start. It sits beside the ALU and feeds the stall unit and the forwarding muxes.

Parameters:
- MULT_CYC, 5, busy cycles for MULT/MULTU (must be at least 1).
- DIV_CYC, 10, busy cycles for DIV/DIVU (must be at least 1, at most 15).

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  E-stage instruction is an md op (qualified by Op).
- Op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 are no-ops.
- A  input  32  forwarded rs value (dividend / multiplicand / mt source).
- B  input  32  forwarded rt value (divisor / multiplier).
- MD_Use_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- Busy  output  1  operation in progress.
- Stall_D  output  1  stall request to the hazard unit.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset (async, Reset_n=0): state IDLE, counter 0, Busy=0, HI=0, LO=0, pending result regs 0. Reset mid-operation aborts the op; HI/LO stay 0 after release.
- States: IDLE, RUN.
- IDLE, Start=1, Op in 0..3:
  - Result is computed from A/B this edge into the pending PHI/PLO.
  - Counter loads MULT_CYC or DIV_CYC; go to RUN.
- IDLE, Start=1, Op=4: HI<=A at the edge. Op=5: LO<=A at the edge. No busy.
- RUN: counter decrements each edge. When the counter reaches 1, the next edge commits HI<=PHI, LO<=PLO and returns to IDLE.
- Timing: Start sampled at edge T. Busy=1 during cycles T+1..T+N. New HI/LO visible from cycle T+N+1, where Busy=0.
- Busy=1 exactly in RUN.
- Stall_D = MD_Use_D & (Busy | (Start & Op<=3)). Combinational, no registered delay.
- Start while RUN: ignored. HI/LO and counter are unaffected. The pipeline never issues this; the bench checks it anyway.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=upper, LO=lower.
  - MULTU: unsigned.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
- Divisor 0 (DIV/DIVU): runs the full DIV_CYC busy period; HI/LO unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Op 6/7 with Start=1: no effect, no stall contribution.
- Operands are captured at the start edge only; later changes on A/B during RUN have no effect.

Test Plan:
- Reset: Reset_n low mid-cycle -> HI=LO=0, Busy=0 immediately. Start MULT 3*4, then assert Reset_n=0 at cycle T+2 -> after release, Busy=0 and HI=LO=0.
- MULT signed: A=0xFFFFFFFE (-2), B=3, Start at T -> Busy high T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU: A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV signed and overflow:
  - A=-7, B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU by 0 with HI=0x11, LO=0x22 -> both unchanged after 10 busy cycles.
- Stall:
  - MD_Use_D=1 in the same cycle as Start MULT -> Stall_D=1.
  - MD_Use_D=1 through the busy window -> Stall_D=1 until the commit edge, 0 in cycle T+6.
  - MD_Use_D=1 with Start MTHI -> Stall_D=0.
- MTHI/MTLO and ignored start:
  - MTHI A=0xDEADBEEF -> HI=0xDEADBEEF the next cycle, Busy stays 0.
  - Start DIV while RUN from MULT 3*4 -> commit gives LO=12, HI=0, Busy drops after 5 cycles only.

Source files
------------

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller: owns HI/LO, runs a fixed-latency busy
// window per mult/div op and requests a D-stage stall for HI/LO-dependent instructions.
module md_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MD_Use_D,
  output logic        Busy,
  output logic        Stall_D,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   phi_q, plo_q;
  logic [31:0]   hi_q, lo_q;
  logic          busy_q;
  logic [63:0]   res_d;

  // Returns {hi, lo}. A zero divisor hands back the current HI/LO so the commit is a no-op.
  function automatic logic [63:0] md_calc(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] hi,
                                          input logic [31:0] lo);
    logic signed [63:0] ps;
    logic signed [31:0] sa, sb, qs, rs;
    logic [63:0]        r;
    sa = $signed(a);
    sb = $signed(b);
    ps = '0;
    qs = '0;
    rs = '0;
    r  = {hi, lo};
    case (op)
      3'd0: begin
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r  = ps;
      end
      3'd1: r = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) begin
          r = {hi, lo};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'h0, 32'h8000_0000};
        end else begin
          qs = sa / sb;
          rs = sa % sb;
          r  = {rs, qs};
        end
      end
      3'd3: begin
        if (b == 32'h0) r = {hi, lo};
        else            r = {a % b, a / b};
      end
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  always_comb begin
    res_d = md_calc(Op, A, B, hi_q, lo_q);
    cnt_d = Op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            case (Op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                {phi_q, plo_q} <= res_d;
                cnt_q          <= cnt_d;
                state_q        <= RUN;
                busy_q         <= 1'b1;
              end
              3'd4:    hi_q <= A;
              3'd5:    lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Starts arriving here are dropped; the pipeline is expected to stall them.
          if (cnt_q == CW'(1)) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Stall_D = MD_Use_D & (busy_q | (Start & ~Op[2]));
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: reference model of HI/LO/busy timing checked every
// cycle, plus literal expectations for each scenario.
module tb_md_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        MD_Use_D;
  logic        Busy, Stall_D;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  // Model state: architectural HI/LO, pending result, cycles left in the busy window.
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  int          m_left;

  md_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .MD_Use_D(MD_Use_D), .Busy(Busy), .Stall_D(Stall_D), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Reset_n) begin
    longint          sa, sb, q, r;
    longint unsigned ua, ub, pu;
    if (!Reset_n) begin
      m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else if (Start) begin
      sa = $signed(A); sb = $signed(B);
      ua = A;          ub = B;
      case (Op)
        3'd0: begin q = sa * sb; m_ph = q[63:32]; m_pl = q[31:0]; m_left = 5; end
        3'd1: begin pu = ua * ub; m_ph = pu[63:32]; m_pl = pu[31:0]; m_left = 5; end
        3'd2: begin
          if (B == 0) begin m_ph = m_hi; m_pl = m_lo; end
          else begin q = sa / sb; r = sa % sb; m_ph = r[31:0]; m_pl = q[31:0]; end
          m_left = 10;
        end
        3'd3: begin
          if (B == 0) begin m_ph = m_hi; m_pl = m_lo; end
          else begin pu = ua / ub; m_pl = pu[31:0]; pu = ua % ub; m_ph = pu[31:0]; end
          m_left = 10;
        end
        3'd4: m_hi = A;
        3'd5: m_lo = A;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp();
    logic exp_stall;
    exp_stall = MD_Use_D && ((m_left > 0) || (Start && Op <= 3'd3));
    chk("model_busy", 32'(Busy), 32'(m_left > 0));
    chk("model_stall", 32'(Stall_D), 32'(exp_stall));
    chk("model_hi", HI, m_hi);
    chk("model_lo", LO, m_lo);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; Op = op; A = a; B = 32'h0;
    tick();
    Start = 1'b0;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic use_d, input logic [31:0] ehi,
                        input logic [31:0] elo, input string nm);
    Start = 1'b1; Op = op; A = a; B = b; MD_Use_D = use_d;
    #1;
    chk({nm, "_stall_start"}, 32'(Stall_D), 32'(use_d));
    tick();
    Start = 1'b0; A = $urandom; B = $urandom;
    for (int i = 1; i <= n; i++) begin
      chk({nm, "_busy"}, 32'(Busy), 32'h1);
      chk({nm, "_stall_run"}, 32'(Stall_D), 32'(use_d));
      tick();
    end
    chk({nm, "_busy_end"}, 32'(Busy), 32'h0);
    chk({nm, "_stall_end"}, 32'(Stall_D), 32'h0);
    chk({nm, "_hi"}, HI, ehi);
    chk({nm, "_lo"}, LO, elo);
    MD_Use_D = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'h0; B = 32'h0; MD_Use_D = 1'b0;
    fork
      forever begin
        @(negedge Clk);
        if (cmp_en) cmp();
      end
    join_none
    #2 Reset_n = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    Reset_n = 1'b1;
    tick();

    // MTHI with a dependent D-stage instruction: no stall, no busy.
    Start = 1'b1; Op = 3'd4; A = 32'hDEAD_BEEF; MD_Use_D = 1'b1;
    #1 chk("mthi_stall", 32'(Stall_D), 32'h0);
    tick();
    Start = 1'b0; MD_Use_D = 1'b0;
    chk("mthi_hi", HI, 32'hDEAD_BEEF);
    chk("mthi_busy", 32'(Busy), 32'h0);

    run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_md(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1, 32'h0, 32'h8000_0000, "div_ovf");
    run_md(3'd3, 32'd100, 32'd7, 10, 1'b0, 32'd2, 32'd14, "divu");

    mt(3'd4, 32'h11);
    mt(3'd5, 32'h22);
    run_md(3'd3, 32'd5, 32'd0, 10, 1'b0, 32'h11, 32'h22, "divu_zero");

    // Starts during RUN (a DIV and an MTHI) must be dropped.
    Start = 1'b1; Op = 3'd0; A = 32'd3; B = 32'd4;
    tick();
    Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
    tick();
    Op = 3'd4; A = 32'h55;
    tick();
    Start = 1'b0;
    chk("ign_hi_mid", HI, 32'h11);
    repeat (2) tick();
    chk("ign_busy_t5", 32'(Busy), 32'h1);
    tick();
    chk("ign_busy_t6", 32'(Busy), 32'h0);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'd12);

    // Op 6 is a no-op even with a dependent D-stage instruction.
    Start = 1'b1; Op = 3'd6; A = 32'h1234; MD_Use_D = 1'b1;
    #1 chk("nop_stall", 32'(Stall_D), 32'h0);
    tick();
    Start = 1'b0; MD_Use_D = 1'b0;
    chk("nop_busy", 32'(Busy), 32'h0);
    chk("nop_lo", LO, 32'd12);

    // Reset in the middle of a MULT aborts it.
    Start = 1'b1; Op = 3'd0; A = 32'd3; B = 32'd4;
    tick();
    Start = 1'b0;
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("rmid_busy", 32'(Busy), 32'h0);
    chk("rmid_lo", LO, 32'h0);
    tick();
    Reset_n = 1'b1;
    repeat (6) tick();
    chk("rpost_busy", 32'(Busy), 32'h0);
    chk("rpost_hi", HI, 32'h0);
    chk("rpost_lo", LO, 32'h0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
